i2c_write_sequencer: RTL and testbench

- Upstream command stage for i2c_master: buffers single-byte write commands (7-bit slave address + data byte) in a FIFO.
- Issues the commands to the master one at a time and tracks completion.
- Retries NACKed commands with a backoff gap, and reports commands that finally fail together with their error code.
- Lets firmware or a register bank queue bursts of device writes without polling the master.

---
 rtl/i2c_write_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_sequencer.sv
// Command FIFO and retry sequencer that feeds single-byte writes to an i2c_master.
// Commands retire in order; NACKs retry after a backoff gap, and final failures are reported.
module i2c_write_sequencer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned BACKOFF_CYC = 1000,
    parameter int unsigned START_TMO   = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [6:0]             cmd_addr_i,
    input  logic [7:0]             cmd_data_i,
    input  logic                   flush_i,
    output logic                   m_start_o,
    output logic [6:0]             m_slave_addr_o,
    output logic [7:0]             m_data_o,
    input  logic                   m_busy_i,
    input  logic                   m_done_i,
    input  logic [1:0]             m_error_i,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   idle_o,
    output logic                   err_valid_o,
    output logic [1:0]             err_code_o,
    output logic [6:0]             err_addr_o,
    output logic [7:0]             err_data_o,
    output logic [15:0]            cmpl_count_o
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned TMAX = (BACKOFF_CYC > START_TMO) ? BACKOFF_CYC : START_TMO;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned RW   = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        StIdle, StIssue, StWaitBusy, StWaitEnd, StBackoff, StRetireOk, StRetireFail
    } state_e;

    state_e        state_q, state_d;
    logic [14:0]   mem_q [DEPTH];
    logic [CW-1:0] wr_q, rd_q, count;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q;
    logic [1:0]    code_q, code_d;
    logic          done_seen_q, flush_seen_q;
    logic          push, pop, in_flight, flush_hit;
    logic [14:0]   head;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign count     = wr_q - rd_q;
    assign head      = mem_q[rd_q[AW-1:0]];
    assign flush_hit = flush_seen_q | flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        code_d  = code_q;
        case (state_q)
            StIdle: begin
                if (count != '0 && !flush_i) state_d = StIssue;
            end
            StIssue: state_d = StWaitBusy;
            StWaitBusy: begin
                if (m_busy_i) begin
                    state_d = StWaitEnd;
                end else if (timer_q == TW'(START_TMO - 1)) begin
                    state_d = StRetireFail;
                    code_d  = 2'd3;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitEnd: begin
                if (!m_busy_i) begin
                    if (m_error_i == 2'd3) begin
                        state_d = StRetireFail;
                        code_d  = 2'd3;
                    end else if (m_error_i != 2'd0) begin
                        code_d  = m_error_i;
                        state_d = (retry_q < RW'(MAX_RETRY) && !flush_hit) ? StBackoff
                                                                           : StRetireFail;
                    end else if (done_seen_q || m_done_i) begin
                        state_d = StRetireOk;
                    end else begin
                        state_d = StRetireFail;
                        code_d  = 2'd3;
                    end
                end
            end
            StBackoff: begin
                if (flush_i) begin
                    state_d = StRetireFail;
                end else if (timer_q == TW'(BACKOFF_CYC - 1)) begin
                    state_d = StIssue;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRetireOk:   state_d = StIdle;
            StRetireFail: state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    always_comb begin
        m_start_o      = (state_q == StIssue);
        err_valid_o    = (state_q == StRetireFail);
        pop            = (state_q == StRetireOk) || (state_q == StRetireFail);
        in_flight      = (state_q != StIdle);
        idle_o         = (state_q == StIdle) && (count == '0);
        cmd_ready_o    = (count != CW'(DEPTH));
        push           = cmd_valid_i && cmd_ready_o && !flush_i;
        fifo_count_o   = count;
        m_slave_addr_o = head[14:8];
        m_data_o       = head[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_q[AW-1:0]] <= {cmd_addr_i, cmd_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q         <= '0;
            rd_q         <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            code_q       <= '0;
            done_seen_q  <= 1'b0;
            flush_seen_q <= 1'b0;
            cmpl_count_o <= '0;
            err_code_o   <= '0;
            err_addr_o   <= '0;
            err_data_o   <= '0;
        end else begin
            rd_q    <= rd_q + {{AW{1'b0}}, pop};
            timer_q <= timer_d;
            code_q  <= code_d;
            // Flush keeps only the in-flight head entry, if any.
            if (flush_i) begin
                wr_q <= rd_q + {{AW{1'b0}}, in_flight};
            end else if (push) begin
                wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            end
            if (state_q == StWaitEnd && state_d == StBackoff) begin
                retry_q <= retry_q + 1'b1;
            end else if (pop || state_q == StIdle) begin
                retry_q <= '0;
            end
            if (state_q == StIssue) begin
                done_seen_q <= 1'b0;
            end else if (m_done_i) begin
                done_seen_q <= 1'b1;
            end
            if (pop || state_q == StIdle) begin
                flush_seen_q <= 1'b0;
            end else if (flush_i) begin
                flush_seen_q <= 1'b1;
            end
            if (state_q == StRetireOk) cmpl_count_o <= cmpl_count_o + 16'd1;
            if (state_d == StRetireFail && state_q != StRetireFail) begin
                err_code_o <= code_d;
                err_addr_o <= head[14:8];
                err_data_o <= head[7:0];
            end
        end
    end
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: a behavioural master answers each start from a response plan,
// and a command-level model predicts starts, drops and completions.
module tb_i2c_write_sequencer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned BACKOFF_CYC = 10;
    localparam int unsigned START_TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        flush;
    logic        m_start;
    logic [6:0]  m_slave_addr;
    logic [7:0]  m_data;
    logic        m_busy;
    logic        m_done;
    logic [1:0]  m_error;
    logic [3:0]  fifo_count;
    logic        idle;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [6:0]  err_addr;
    logic [7:0]  err_data;
    logic [15:0] cmpl_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_len = 5;
    bit hold = 1'b0;

    // Master response per attempt: 0 ok, 1/2/3 error code, 4 never raises busy.
    int          resp_q[$];
    int          plan_q[$];
    logic [14:0] cmd_q[$];
    logic [14:0] starts_log[$];
    int          start_cyc[$];
    logic [16:0] err_log[$];
    int          err_cyc[$];
    logic [14:0] exp_starts[$];
    logic [16:0] exp_errs[$];
    int          exp_cmpl = 0;

    i2c_write_sequencer #(
        .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .BACKOFF_CYC(BACKOFF_CYC), .START_TMO(START_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .flush_i(flush),
        .m_start_o(m_start), .m_slave_addr_o(m_slave_addr), .m_data_o(m_data),
        .m_busy_i(m_busy), .m_done_i(m_done), .m_error_i(m_error),
        .fifo_count_o(fifo_count), .idle_o(idle),
        .err_valid_o(err_valid), .err_code_o(err_code),
        .err_addr_o(err_addr), .err_data_o(err_data), .cmpl_count_o(cmpl_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && err_valid === 1'b1) begin
            err_log.push_back({err_code, err_addr, err_data});
            err_cyc.push_back(cyc);
        end
    end

    always begin : master
        int r;
        @(negedge clk);
        if (rst_n === 1'b1 && m_start === 1'b1) begin
            r = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
            starts_log.push_back({m_slave_addr, m_data});
            start_cyc.push_back(cyc);
            if (r != 4) begin
                @(negedge clk);
                m_busy = 1'b1;
                for (int i = 0; i < busy_len || hold; i++) @(negedge clk);
                m_busy  = 1'b0;
                m_done  = (r == 0);
                m_error = 2'(r);
                @(negedge clk);
                m_done  = 1'b0;
                m_error = 2'd0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [6:0] a, input logic [7:0] d, output bit acc);
        @(negedge clk);
        acc       = cmd_ready;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (idle !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, idle}, 32'd1);
    endtask

    task automatic clear_logs();
        starts_log.delete(); start_cyc.delete(); err_log.delete(); err_cyc.delete();
        cmd_q.delete(); plan_q.delete(); resp_q.delete();
        exp_starts.delete(); exp_errs.delete();
    endtask

    task automatic add_resp(input int r);
        plan_q.push_back(r);
        resp_q.push_back(r);
    endtask

    // Command-level outcome: each command gets up to 1+MAX_RETRY attempts; only NACKs retry.
    task automatic run_model();
        int pi;
        int r;
        pi = 0;
        foreach (cmd_q[i]) begin
            for (int a = 0; a <= int'(MAX_RETRY); a++) begin
                r = (pi < plan_q.size()) ? plan_q[pi] : 0;
                pi++;
                exp_starts.push_back(cmd_q[i]);
                if (r == 0) begin
                    exp_cmpl++;
                    break;
                end
                if (r >= 3 || a == int'(MAX_RETRY)) begin
                    exp_errs.push_back({(r >= 3) ? 2'd3 : 2'(r), cmd_q[i]});
                    break;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s.nstart", tag), starts_log.size(), exp_starts.size());
        for (int i = 0; i < exp_starts.size() && i < starts_log.size(); i++)
            check($sformatf("%s.start%0d", tag, i), {17'd0, starts_log[i]}, {17'd0, exp_starts[i]});
        check($sformatf("%s.nerr", tag), err_log.size(), exp_errs.size());
        for (int i = 0; i < exp_errs.size() && i < err_log.size(); i++)
            check($sformatf("%s.err%0d", tag, i), {15'd0, err_log[i]}, {15'd0, exp_errs[i]});
        check($sformatf("%s.cmpl", tag), {16'd0, cmpl_count}, {16'd0, 16'(exp_cmpl)});
    endtask

    initial begin
        bit          acc;
        int          n_acc;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [14:0] first;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; flush = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_error = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst.ready", {31'd0, cmd_ready}, 32'd1);
        check("rst.idle", {31'd0, idle}, 32'd1);
        check("rst.start", {31'd0, m_start}, 32'd0);
        check("rst.count", {28'd0, fifo_count}, 32'd0);
        check("rst.errv", {31'd0, err_valid}, 32'd0);
        check("rst.cmpl", {16'd0, cmpl_count}, 32'd0);

        // Single command: start latency and head outputs
        clear_logs();
        busy_len = 20;
        push(7'h50, 8'hA5, acc);
        cmd_q.push_back({7'h50, 8'hA5});
        @(negedge clk);
        check("t1.start_early", {31'd0, m_start}, 32'd0);
        @(negedge clk);
        check("t1.start", {31'd0, m_start}, 32'd1);
        check("t1.addr", {25'd0, m_slave_addr}, 32'h50);
        check("t1.data", {24'd0, m_data}, 32'hA5);
        wait_idle("t1.idle", 500);
        run_model();
        check_model("t1");

        // NACK then success: retry after backoff
        clear_logs();
        busy_len = 3 + int'($urandom_range(0, 5));
        add_resp(1);
        add_resp(0);
        a = 7'($urandom); d = 8'($urandom);
        push(a, d, acc);
        cmd_q.push_back({a, d});
        wait_idle("t2.idle", 500);
        run_model();
        check_model("t2");
        if (start_cyc.size() >= 2)
            check("t2.gap", start_cyc[1] - start_cyc[0], busy_len + 2 + int'(BACKOFF_CYC));

        // Persistent NACK_DATA drops the command; the next entry still issues
        clear_logs();
        busy_len = 4;
        add_resp(2); add_resp(2); add_resp(2);
        for (int i = 0; i < 2; i++) begin
            a = 7'($urandom); d = 8'($urandom);
            push(a, d, acc);
            cmd_q.push_back({a, d});
        end
        wait_idle("t3.idle", 1000);
        run_model();
        check_model("t3");

        // Fill to capacity while the master is held busy
        clear_logs();
        busy_len = 4;
        hold = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            a = 7'($urandom); d = 8'($urandom);
            push(a, d, acc);
            if (acc) begin
                cmd_q.push_back({a, d});
                n_acc++;
            end
        end
        check("t4.ninth_rejected", {31'd0, acc}, 32'd0);
        check("t4.accepted", n_acc, 8);
        @(negedge clk);
        check("t4.ready", {31'd0, cmd_ready}, 32'd0);
        check("t4.count", {28'd0, fifo_count}, 32'd8);
        hold = 1'b0;
        wait_idle("t4.idle", 2000);
        run_model();
        check_model("t4");

        // Flush during a NACKed transaction: no retry, queue emptied, same-cycle push dropped
        clear_logs();
        busy_len = 3;
        hold = 1'b1;
        add_resp(1);
        for (int i = 0; i < 5; i++) begin
            a = 7'($urandom); d = 8'($urandom);
            push(a, d, acc);
            cmd_q.push_back({a, d});
        end
        first = cmd_q[0];
        repeat (2) @(negedge clk);
        flush = 1'b1; cmd_valid = 1'b1; cmd_addr = 7'h11; cmd_data = 8'h22;
        @(posedge clk);
        #1;
        flush = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("t5.count_in_flight", {28'd0, fifo_count}, 32'd1);
        hold = 1'b0;
        wait_idle("t5.idle", 500);
        check("t5.nerr", err_log.size(), 1);
        if (err_log.size() > 0) check("t5.err", {15'd0, err_log[0]}, {15'd0, 2'd1, first});
        check("t5.count", {28'd0, fifo_count}, 32'd0);
        check("t5.cmpl", {16'd0, cmpl_count}, {16'd0, 16'(exp_cmpl)});
        repeat (30) @(negedge clk);
        check("t5.nstart", starts_log.size(), 1);

        // Master never raises busy: start timeout
        clear_logs();
        add_resp(4);
        push(7'h2A, 8'h3C, acc);
        cmd_q.push_back({7'h2A, 8'h3C});
        wait_idle("t6.idle", 500);
        run_model();
        check_model("t6");
        if (err_cyc.size() > 0 && start_cyc.size() > 0)
            check("t6.latency", err_cyc[0] - start_cyc[0], 16);

        // Randomized burst with a random response plan
        clear_logs();
        busy_len = 2 + int'($urandom_range(0, 7));
        for (int i = 0; i < 18; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            add_resp((r > 4) ? 0 : r);
        end
        for (int i = 0; i < 6; i++) begin
            a = 7'($urandom); d = 8'($urandom);
            push(a, d, acc);
            cmd_q.push_back({a, d});
        end
        wait_idle("t7.idle", 5000);
        run_model();
        check_model("t7");
        resp_q.delete();

        // Asynchronous reset in the middle of WAIT_END
        clear_logs();
        hold = 1'b1;
        push(7'h33, 8'h44, acc);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t8.ready", {31'd0, cmd_ready}, 32'd1);
        check("t8.idle", {31'd0, idle}, 32'd1);
        check("t8.start", {31'd0, m_start}, 32'd0);
        check("t8.count", {28'd0, fifo_count}, 32'd0);
        check("t8.errv", {31'd0, err_valid}, 32'd0);
        check("t8.errcode", {30'd0, err_code}, 32'd0);
        check("t8.erraddr", {25'd0, err_addr}, 32'd0);
        check("t8.errdata", {24'd0, err_data}, 32'd0);
        check("t8.cmpl", {16'd0, cmpl_count}, 32'd0);
        check("t8.addr", {25'd0, m_slave_addr}, 32'd0);
        check("t8.data", {24'd0, m_data}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
